// File: rtl/kpg_iterative_adder_ctrl_pkg.sv
// kpg_iterative_adder_ctrl_pkg: shared KPG encodings, FSM state codes and combine helpers
//   KPG_KILL/KPG_GEN : resolved carry-status encodings (propagate is 01/10)
//   WIDTH_DEF        : default operand width
//   S_IDLE/S_ITER/S_DONE : controller state encodings
//   kpg_is_prop()    : propagate test
//   kpg_combine()    : two-input KPG combine cell, hi dominates unless it propagates
package kpg_iterative_adder_ctrl_pkg;

    localparam logic [1:0] KPG_KILL = 2'b00;
    localparam logic [1:0] KPG_GEN  = 2'b11;

    localparam int WIDTH_DEF = 24;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic kpg_is_prop(input logic [1:0] k);
        return k[1] ^ k[0];
    endfunction

    function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
        return kpg_is_prop(hi) ? lo : hi;
    endfunction

endpackage

// File: rtl/kpg_iterative_adder_ctrl_prefix_row.sv
// kpg_prefix_row: one combinational row of KPG combine cells with selectable combine distance
//   r_in      : current per-bit KPG state
//   seed      : KPG value of position -1 (carry-in as kill/generate)
//   iter      : doubling iteration, distance = 1 << iter
//   r_out     : r_in[i] combined with r_in[i-d] (seed where i-d < 0)
//   any_prop  : some position of r_in is still propagate
module kpg_prefix_row
    import kpg_iterative_adder_ctrl_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = $clog2(WIDTH_DEF + 1)
) (
    input  logic [WIDTH-1:0][1:0] r_in,
    input  logic [1:0]            seed,
    input  logic [2:0]            iter,
    output logic [WIDTH-1:0][1:0] r_out,
    output logic                  any_prop
);

    logic [WIDTH-1:0] prop_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [STAGES-1:0][1:0] cand;
        // Candidate lo operand for every distance; positions reaching below bit 0 see the seed.
        for (genvar s = 0; s < STAGES; s++) begin : g_dist
            if (i >= (1 << s)) begin : g_in
                assign cand[s] = r_in[i - (1 << s)];
            end else begin : g_seed
                assign cand[s] = seed;
            end
        end
        assign r_out[i]     = kpg_combine(r_in[i], cand[iter]);
        assign prop_bits[i] = kpg_is_prop(r_in[i]);
    end

    assign any_prop = |prop_bits;

endmodule

// File: rtl/kpg_iterative_adder_ctrl.sv
// kpg_iterative_adder_ctrl: iterative WIDTH-bit adder reusing one KPG prefix row by recursive doubling
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, iters)
//   iters               : doubling iterations actually performed
module kpg_iterative_adder_ctrl
    import kpg_iterative_adder_ctrl_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [2:0]       iters
);

    localparam int         STAGES   = $clog2(WIDTH + 1);
    localparam logic [2:0] STAGES_3 = 3'(STAGES);

    logic [1:0]            state;
    logic [WIDTH-1:0][1:0] r, r_nxt, r_fin, kpg_in;
    logic [WIDTH-1:0]      x, gen;
    logic [1:0]            seed;
    logic                  cin_q, any_prop, early, done_now;
    logic [2:0]            cnt, cnt_nxt;

    kpg_prefix_row #(.WIDTH(WIDTH), .STAGES(STAGES)) u_row (
        .r_in     (r),
        .seed     (seed),
        .iter     (cnt),
        .r_out    (r_nxt),
        .any_prop (any_prop)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign early     = (EARLY_EXIT != 0) && !any_prop;
    assign cnt_nxt   = cnt + 3'd1;
    assign done_now  = early || (cnt_nxt == STAGES_3);
    // On an early exit r is already fully resolved, otherwise the final row output is used.
    assign r_fin     = early ? r : r_nxt;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            kpg_in[i] = {a[i], b[i]};
            gen[i]    = (r_fin[i] == KPG_GEN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            x     <= '0;
            seed  <= KPG_KILL;
            cin_q <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            iters <= '0;
        end else if (state == S_IDLE) begin
            if (in_valid) begin
                r     <= kpg_in;
                x     <= a ^ b;
                seed  <= {cin, cin};
                cin_q <= cin;
                cnt   <= '0;
                state <= S_ITER;
            end
        end else if (state == S_ITER) begin
            if (!early) begin
                r   <= r_nxt;
                cnt <= cnt_nxt;
            end
            if (done_now) begin
                // Carry into bit i is the resolved status of bit i-1; bit 0 takes cin.
                sum   <= x ^ {gen[WIDTH-2:0], cin_q};
                cout  <= gen[WIDTH-1];
                iters <= early ? cnt : cnt_nxt;
                state <= S_DONE;
            end
        end else if (state == S_DONE) begin
            if (out_ready) state <= S_IDLE;
        end else begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_kpg_iterative_adder_ctrl.sv
// tb_kpg_iterative_adder_ctrl: directed checks of the iterative adder with and without early exit
module tb_kpg_iterative_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] a = '0, b = '0;
    logic        cin = 1'b0;

    logic        in_ready_e, out_valid_e, cout_e;
    logic [23:0] sum_e;
    logic [2:0]  iters_e;
    logic        in_ready_f, out_valid_f, cout_f;
    logic [23:0] sum_f;
    logic [2:0]  iters_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kpg_iterative_adder_ctrl #(.WIDTH(24), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid_e), .out_ready(out_ready),
        .sum(sum_e), .cout(cout_e), .iters(iters_e)
    );

    kpg_iterative_adder_ctrl #(.WIDTH(24), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid_f), .out_ready(out_ready),
        .sum(sum_f), .cout(cout_f), .iters(iters_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [23:0] av, input logic [23:0] bv, input logic cv);
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for both instances after the accept edge and checks latency and result.
    task automatic wait_done(input logic [23:0] es, input logic ec, input int it_e, input int it_f);
        int lat_e = 0;
        int lat_f = 0;
        for (int n = 1; n <= 20 && (lat_e == 0 || lat_f == 0); n++) begin
            @(posedge clk);
            #1;
            if (out_valid_e && lat_e == 0) lat_e = n;
            if (out_valid_f && lat_f == 0) lat_f = n;
        end
        chk("lat_ee", lat_e, (it_e >= 5) ? 5 : it_e + 1);
        chk("lat_full", lat_f, (it_f >= 5) ? 5 : it_f + 1);
        chk("sum_ee", sum_e, es);
        chk("sum_full", sum_f, es);
        chk("cout_ee", cout_e, ec);
        chk("cout_full", cout_f, ec);
        chk("iters_ee", iters_e, it_e);
        chk("iters_full", iters_f, it_f);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_ready_ee", in_ready_e, 1);
        chk("rel_ready_full", in_ready_f, 1);
        chk("rel_valid_ee", out_valid_e, 0);
    endtask

    task automatic run_op(input logic [23:0] av, input logic [23:0] bv, input logic cv,
                          input logic [23:0] es, input logic ec, input int it_e, input int it_f);
        start_op(av, bv, cv);
        wait_done(es, ec, it_e, it_f);
        release_result();
    endtask

    initial begin
        #3;
        chk("rst_in_ready", in_ready_e, 1);
        chk("rst_out_valid", out_valid_e, 0);
        chk("rst_sum", sum_e, 0);
        chk("rst_cout", cout_e, 0);
        chk("rst_iters", iters_e, 0);
        chk("rst_full_ready", in_ready_f, 1);
        chk("rst_full_valid", out_valid_f, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(24'h000001, 24'h000001, 1'b0, 24'h000002, 1'b0, 0, 5);
        run_op(24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b1, 5, 5);
        run_op(24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 1'b0, 5, 5);
        run_op(24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 0, 5);

        // Backpressure with ignored operands, then simultaneous out_ready and in_valid.
        start_op(24'h123456, 24'h654321, 1'b0);
        wait_done(24'h777777, 1'b0, 2, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 24'hABCDEF;
            b = 24'h111111;
            cin = 1'b1;
            in_valid = (k == 1);
            chk("bp_sum_ee", sum_e, 24'h777777);
            chk("bp_sum_full", sum_f, 24'h777777);
            chk("bp_valid_ee", out_valid_e, 1);
            chk("bp_in_ready_ee", in_ready_e, 0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_ready_after", in_ready_e, 1);
        chk("bp_valid_after", out_valid_e, 0);
        repeat (3) @(negedge clk);
        chk("bp_no_capture_ee", out_valid_e, 0);
        chk("bp_no_capture_full", out_valid_f, 0);
        chk("bp_idle_ee", in_ready_e, 1);
        chk("bp_sum_hold", sum_e, 24'h777777);

        // Reset after the second ITER update.
        start_op(24'hFFFFFF, 24'h000000, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_ee", out_valid_e, 0);
        chk("mid_rst_ready_ee", in_ready_e, 1);
        chk("mid_rst_valid_full", out_valid_f, 0);
        chk("mid_rst_ready_full", in_ready_f, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid_e, 0);
        run_op(24'h00000F, 24'h000001, 1'b0, 24'h000010, 1'b0, 2, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kpg_iterative_adder_ctrl.md
Name: kpg_iterative_adder_ctrl

Overview:
- Sequential controller that time-multiplexes a single row of WIDTH KPG prefix-combine cells to perform a WIDTH-bit add.
- Uses recursive doubling: the row is applied with combine distances 1, 2, 4, 8, 16 over successive cycles.
- Trades the five-row combinational prefix network for one row plus a sequencer.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 24, operand width in bits.
- STAGES, 5, number of doubling iterations, ceil(log2(WIDTH+1)); derived localparam, not overridable.
- EARLY_EXIT, 1, when 1, stop iterating as soon as no position is still propagate.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  addend
- b  input  WIDTH  addend
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin, low WIDTH bits
- cout  output  1  carry-out
- iters  output  3  doubling iterations actually performed

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
  - Reset forces state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, iters=0, and clears the internal registers.
- KPG encoding, per bit {a[i],b[i]}:
  - 00 = kill, 11 = generate, 01/10 = propagate.
  - Resolved values are normalised to 00 (kill) or 11 (generate).
- Combine rule, combine(hi,lo): result = lo if hi is propagate, else hi.
- Seed (position -1): generate if cin=1, else kill.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load r[i]=kpg(a[i],b[i]), load x=a^b, load seed, iter_cnt=0, go to ITER.
- ITER (in_ready=0):
  - If EARLY_EXIT=1 and no r[i] is propagate: go to DONE with no update.
  - Otherwise: r[i] = combine(r[i], r[i-d]) with d = 1<<iter_cnt; where i-d<0, the lo operand is the seed.
  - Then iter_cnt++. When the new iter_cnt equals STAGES, go to DONE.
- DONE:
  - out_valid=1.
  - carry into bit i = (i==0 ? cin : r[i-1]==generate).
  - sum[i] = x[i]^carry_i.
  - cout = (r[WIDTH-1]==generate).
  - iters = iter_cnt.
  - On out_ready: go to IDLE, deassert out_valid.
- Outputs: sum, cout and iters are registered and stable for the whole time out_valid=1. Outside DONE they hold their last value.
- Latency, accept edge to out_valid:
  - min(iters+1, STAGES) cycles.
  - Always STAGES cycles when EARLY_EXIT=0.
- No overlap: in_valid while not IDLE is ignored and operands are not captured.
- Backpressure: DONE holds indefinitely while out_ready=0. The result must not change.
- Simultaneous out_ready in DONE and in_valid: no accept that cycle. The accept occurs in IDLE the next cycle.
- Reset mid-ITER or mid-DONE: the operation is abandoned immediately and no out_valid is produced.
- Width rule: the iteration counter is 3 bits and never exceeds STAGES.

Decomposition:
- Shared definitions include file kpg_defs:
  - KPG_KILL=2'b00, KPG_GEN=2'b11, propagate test macro.
  - WIDTH default, STAGES.
  - FSM state encodings IDLE=2'd0, ITER=2'd1, DONE=2'd2.
- Sub-module kpg_prefix_row:
  - Purely combinational.
  - WIDTH instances of the existing two-input KPG combine cell.
  - Distance-select mux (1/2/4/8/16) on the lo operands, with seed injection.
  - Outputs the next r and an any_propagate flag.
- Controller owns the FSM, the registers and the sum/cout formation.

Test Plan:
- Early exit on an already-resolved input, EARLY_EXIT=1: a=0x000001, b=0x000001, cin=0 -> sum=0x000002, cout=0, iters=0, out_valid 1 cycle after accept.
- Full propagate chain with carry-in: a=0xFFFFFF, b=0x000000, cin=1 -> sum=0x000000, cout=1, iters=5, latency 5.
- Full propagate chain without carry-in: same operands, cin=0 -> sum=0xFFFFFF, cout=0, iters=5.
- EARLY_EXIT=0, generate at the top bit: a=0x800000, b=0x800000, cin=0 -> sum=0x000000, cout=1, iters=5, latency 5. Repeat case 1 -> iters=5.
- Backpressure: after a=0x123456, b=0x654321, cin=0, hold out_ready=0 for 3 cycles and pulse in_valid with new operands -> sum=0x777777 held stable, in_ready=0, new operands not captured. After out_ready=1, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 after the 2nd ITER update of 0xFFFFFF+0x000000+1 -> out_valid=0, in_ready=1 asynchronously. After release, 0x00000F+0x000001+0 -> sum=0x000010, cout=0.
